// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the RV32I pipeline sequencer
package cpu_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } sb_entry_t;

  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_FREEZE,
    MODE_FLUSH,
    MODE_STALL,
    MODE_NORMAL
  } pipe_mode_e;

  // The producer moves one stage further by the time the consumer reaches EX.
  function automatic logic [1:0] fwd_select(input logic ex_alu_hit, input logic mem_hit);
    if (ex_alu_hit)
      return FWD_EXMEM;
    else if (mem_hit)
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX/MEM/WB destination shadow and ID operand match
module hazard_scoreboard
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       insert,
  input  sb_entry_t  id_entry,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic [1:0] ex_alu_hit,
  output logic [1:0] ex_ld_hit,
  output logic [1:0] mem_hit,
  output logic [1:0] wb_hit
);

  sb_entry_t ex_q, mem_q, wb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (advance) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= insert ? id_entry : '0;
    end
  end

  function automatic logic hit(input sb_entry_t e, input logic [4:0] rs,
                               input logic use_rs, input logic valid);
    return valid && use_rs && e.wr && (e.rd == rs) && (rs != 5'd0);
  endfunction

  logic [1:0] ex_hit;

  // Bit 0 is rs1, bit 1 is rs2.
  assign ex_hit     = {hit(ex_q,  id_rs2, id_use_rs2, id_valid), hit(ex_q,  id_rs1, id_use_rs1, id_valid)};
  assign mem_hit    = {hit(mem_q, id_rs2, id_use_rs2, id_valid), hit(mem_q, id_rs1, id_use_rs1, id_valid)};
  assign wb_hit     = {hit(wb_q,  id_rs2, id_use_rs2, id_valid), hit(wb_q,  id_rs1, id_use_rs1, id_valid)};
  assign ex_alu_hit = ex_hit & {2{~ex_q.ld}};
  assign ex_ld_hit  = ex_hit & {2{ex_q.ld}};

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward sequencer; HAZARD_FORWARD_EN enables forwarding
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             pipe_en,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  sb_entry_t  id_entry;
  logic [1:0] ex_alu_hit, ex_ld_hit, mem_hit, wb_hit;
  logic       freeze, hazard;
  pipe_mode_e mode;

  always_comb begin
    id_entry    = '0;
    id_entry.rd = id_rd;
    id_entry.wr = id_regwrite && (id_rd != 5'd0);
    id_entry.ld = id_memread;
  end

  hazard_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .advance    (pipe_en),
    .insert     (id_valid && !idex_bubble),
    .id_entry   (id_entry),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_alu_hit (ex_alu_hit),
    .ex_ld_hit  (ex_ld_hit),
    .mem_hit    (mem_hit),
    .wb_hit     (wb_hit)
  );

  assign freeze = mem_req && !mem_ready;

`ifdef HAZARD_FORWARD_EN
  // A WB producer is only a problem when no younger copy of rd can be forwarded.
  assign hazard = (|ex_ld_hit) || (|(wb_hit & ~(ex_alu_hit | ex_ld_hit | mem_hit)));
`else
  assign hazard = |(ex_alu_hit | ex_ld_hit | mem_hit | wb_hit);
`endif

  always_comb begin
    if (rst)
      mode = MODE_RESET;
    else if (freeze)
      mode = MODE_FREEZE;
    else if (ex_branch_taken)
      mode = MODE_FLUSH;
    else if (hazard)
      mode = MODE_STALL;
    else
      mode = MODE_NORMAL;
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    pipe_en     = 1'b0;
    idex_bubble = 1'b0;
    case (mode)
      MODE_RESET: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      MODE_FREEZE: ;
      MODE_FLUSH: begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        pipe_en     = 1'b1;
        idex_bubble = 1'b1;
      end
      MODE_STALL: begin
        pipe_en     = 1'b1;
        idex_bubble = 1'b1;
      end
      default: begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        pipe_en = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (mode == MODE_STALL && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd_a_q, fwd_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else if (pipe_en) begin
      if (mode == MODE_NORMAL) begin
        fwd_a_q <= fwd_select(ex_alu_hit[0], mem_hit[0]);
        fwd_b_q <= fwd_select(ex_alu_hit[1], mem_hit[1]);
      end else begin
        fwd_a_q <= FWD_REG;
        fwd_b_q <= FWD_REG;
      end
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
`else
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench for hazard_ctrl (both HAZARD_FORWARD_EN builds)
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

`ifdef HAZARD_FORWARD_EN
  localparam int         NS_ADJ = 0;
  localparam int         NS_LU  = 1;
  localparam logic [1:0] F_EX   = 2'b01;
  localparam logic [1:0] F_WB   = 2'b10;
`else
  localparam int         NS_ADJ = 3;
  localparam int         NS_LU  = 3;
  localparam logic [1:0] F_EX   = 2'b00;
  localparam logic [1:0] F_WB   = 2'b00;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid = 1'b0;
  logic [4:0]       id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic             id_regwrite = 1'b0, id_memread = 1'b0;
  logic             ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic             pc_en, ifid_en, ifid_flush, pipe_en, idex_bubble;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .pipe_en(pipe_en),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
  endtask

  task automatic id_nop;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    rst = 1'b1; id_nop(); ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; id_nop();
    tick(); #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en got %b exp 0", pc_en); end
    checks++; if (ifid_en !== 1'b0) begin errors++; $display("FAIL reset_ifid_en got %b exp 0", ifid_en); end
    checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL reset_pipe_en got %b exp 0", pipe_en); end
    checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL reset_flush got %b exp 1", ifid_flush); end
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL reset_bubble got %b exp 1", idex_bubble); end
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd got %b/%b exp 00/00", fwd_a, fwd_b); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
    rst = 1'b0; #1;
    checks++; if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL release_normal got pc_en %b bubble %b exp 1 0", pc_en, idex_bubble); end
  endtask

  // add x5,x1,x2 ; add x6,x5,x3
  task automatic test_add_pair;
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL add_prod_pc got %b exp 1", pc_en); end
    tick();
    set_id(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0); #1;
    for (int i = 0; i < NS_ADJ; i++) begin
      checks++; if (pc_en !== 1'b0 || idex_bubble !== 1'b1) begin errors++; $display("FAIL add_stall_%0d got pc_en %b bubble %b exp 0 1", i, pc_en, idex_bubble); end
      tick();
    end
    checks++; if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL add_advance got pc_en %b bubble %b exp 1 0", pc_en, idex_bubble); end
    tick(); id_nop(); #1;
    checks++; if (fwd_a !== F_EX) begin errors++; $display("FAIL add_fwd_a got %b exp %b", fwd_a, F_EX); end
    checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL add_fwd_b got %b exp 00", fwd_b); end
    checks++; if (stall_cnt !== CNT_W'(NS_ADJ)) begin errors++; $display("FAIL add_cnt got %0d exp %0d", stall_cnt, NS_ADJ); end
  endtask

  // lw x5,0(x1) ; add x6,x5,x5
  task automatic test_load_use;
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
    tick();
    set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0); #1;
    for (int i = 0; i < NS_LU; i++) begin
      checks++; if (pc_en !== 1'b0 || ifid_en !== 1'b0 || pipe_en !== 1'b1 || idex_bubble !== 1'b1) begin
        errors++; $display("FAIL lu_stall_%0d got pc %b ifid %b pipe %b bub %b exp 0 0 1 1", i, pc_en, ifid_en, pipe_en, idex_bubble); end
      tick();
    end
    checks++; if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL lu_advance got pc_en %b bubble %b exp 1 0", pc_en, idex_bubble); end
    tick(); id_nop(); #1;
    checks++; if (fwd_a !== F_WB || fwd_b !== F_WB) begin errors++; $display("FAIL lu_fwd got %b/%b exp %b/%b", fwd_a, fwd_b, F_WB, F_WB); end
    checks++; if (stall_cnt !== CNT_W'(NS_LU)) begin errors++; $display("FAIL lu_cnt got %0d exp %0d", stall_cnt, NS_LU); end
  endtask

  // Producer three instructions ahead sits in WB while the consumer reads.
  task automatic test_wb_read;
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    tick(); id_nop(); tick(); tick();
    set_id(1, 5'd5, 5'd0, 1, 0, 5'd7, 1, 0); #1;
    checks++; if (pc_en !== 1'b0 || idex_bubble !== 1'b1) begin errors++; $display("FAIL wb_stall got pc_en %b bubble %b exp 0 1", pc_en, idex_bubble); end
    tick();
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL wb_release got %b exp 1", pc_en); end
    tick(); id_nop(); #1;
    checks++; if (fwd_a !== 2'b00 || stall_cnt !== CNT_W'(1)) begin errors++; $display("FAIL wb_after got fwd %b cnt %0d exp 00 1", fwd_a, stall_cnt); end
  endtask

  // add x5 ; add x5,x7 ; add x6,x5,x5 -> youngest producer wins
  task automatic test_priority;
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); tick();
    set_id(1, 5'd7, 5'd0, 1, 1, 5'd5, 1, 0); tick();
    set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0); #1;
    for (int i = 0; i < NS_ADJ; i++) begin
      checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL prio_stall_%0d got %b exp 0", i, pc_en); end
      tick();
    end
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL prio_advance got %b exp 1", pc_en); end
    tick(); id_nop(); #1;
    checks++; if (fwd_a !== F_EX || fwd_b !== F_EX) begin errors++; $display("FAIL prio_fwd got %b/%b exp %b/%b", fwd_a, fwd_b, F_EX, F_EX); end
  endtask

  task automatic test_branch_flush;
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
    set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0); ex_branch_taken = 1'b1; #1;
    checks++; if (ifid_flush !== 1'b1 || idex_bubble !== 1'b1) begin errors++; $display("FAIL br_flush got flush %b bubble %b exp 1 1", ifid_flush, idex_bubble); end
    checks++; if (pc_en !== 1'b1 || ifid_en !== 1'b1 || pipe_en !== 1'b1) begin errors++; $display("FAIL br_en got pc %b ifid %b pipe %b exp 1 1 1", pc_en, ifid_en, pipe_en); end
    tick(); ex_branch_taken = 1'b0; id_nop(); #1;
    checks++; if (stall_cnt !== '0 || fwd_a !== 2'b00) begin errors++; $display("FAIL br_after got cnt %0d fwd %b exp 0 00", stall_cnt, fwd_a); end
  endtask

  task automatic test_freeze;
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
    set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
    mem_req = 1'b1; mem_ready = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (pipe_en !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL frz_hold_%0d got pipe %b pc %b exp 0 0", i, pipe_en, pc_en); end
      tick();
    end
    mem_ready = 1'b1; #1;
    checks++; if (pc_en !== 1'b0 || idex_bubble !== 1'b1) begin errors++; $display("FAIL frz_state_kept got pc %b bubble %b exp 0 1", pc_en, idex_bubble); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL frz_cnt got %0d exp 0", stall_cnt); end
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
    set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
    ex_branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc_en !== 1'b0 || ifid_en !== 1'b0 || pipe_en !== 1'b0 || ifid_flush !== 1'b0) begin
        errors++; $display("FAIL frz_br_%0d got pc %b ifid %b pipe %b flush %b exp 0 0 0 0", i, pc_en, ifid_en, pipe_en, ifid_flush); end
      tick();
    end
    mem_ready = 1'b1; #1;
    checks++; if (ifid_flush !== 1'b1 || pc_en !== 1'b1) begin errors++; $display("FAIL frz_br_flush got flush %b pc %b exp 1 1", ifid_flush, pc_en); end
    tick(); ex_branch_taken = 1'b0; mem_req = 1'b0; id_nop(); #1;
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL frz_br_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_x0;
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0); tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0); #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL x0_alu_pc got %b exp 1", pc_en); end
    tick(); id_nop(); #1;
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL x0_fwd got %b/%b exp 00/00", fwd_a, fwd_b); end
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1); tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0); #1;
    checks++; if (pc_en !== 1'b1 || stall_cnt !== '0) begin errors++; $display("FAIL x0_load got pc %b cnt %0d exp 1 0", pc_en, stall_cnt); end
  endtask

  task automatic test_reset_mid_stall;
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
    set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0); #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL rms_stall got %b exp 0", pc_en); end
    tick();
    checks++; if (stall_cnt !== CNT_W'(1)) begin errors++; $display("FAIL rms_counted got %0d exp 1", stall_cnt); end
    rst = 1'b1;
    tick();
    checks++; if (stall_cnt !== '0 || fwd_a !== 2'b00) begin errors++; $display("FAIL rms_cleared got cnt %0d fwd %b exp 0 00", stall_cnt, fwd_a); end
    rst = 1'b0; #1;
    checks++; if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL rms_no_stale got pc %b bubble %b exp 1 0", pc_en, idex_bubble); end
  endtask

  task automatic test_saturate;
    do_reset();
    for (int p = 0; p < 17; p++) begin
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
      set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0); #1;
      for (int g = 0; g < 10 && pc_en !== 1'b1; g++) tick();
      checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL sat_timeout_%0d got pc %b exp 1", p, pc_en); end
      tick();
    end
    id_nop(); #1;
    checks++; if (stall_cnt !== '1) begin errors++; $display("FAIL sat_cnt got %0d exp %0d", stall_cnt, (1 << CNT_W) - 1); end
  endtask

  initial begin
    test_reset();
    test_add_pair();
    test_load_use();
    test_wb_read();
    test_priority();
    test_branch_flush();
    test_freeze();
    test_x0();
    test_reset_mid_stall();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencer for the 5-stage RV32I core. It tracks destination registers in flight in EX, MEM and WB and detects RAW hazards against the operands decoded in ID. It drives stall, bubble and flush controls for PC, IF/ID and ID/EX, and emits registered forwarding selects for the EX stage. It sits beside the decode stage and consumes its rs1/rs2/rd and control outputs, plus branch resolution from EX and memory handshake from MEM.

## Interface
- `CNT_W`, default 16: width of saturating stall-cycle counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in 5: source fields from decode.
- `id_use_rs1`, `id_use_rs2` in 1: operand actually read (R/branch/store use both; I/load use rs1 only).
- `id_rd` in 5, `id_regwrite` in 1, `id_memread` in 1: decode controls of the ID instruction.
- `ex_branch_taken` in 1: beq resolved taken in EX this cycle.
- `mem_req` in 1, `mem_ready` in 1: MEM-stage data memory handshake.
- `pc_en` out 1: PC update enable.
- `ifid_en` out 1, `ifid_flush` out 1: IF/ID load enable; on load, flush inserts NOP.
- `pipe_en` out 1: load enable for ID/EX, EX/MEM and MEM/WB.
- `idex_bubble` out 1: on load, ID/EX receives NOP with all controls 0.
- `fwd_a`, `fwd_b` out 2: registered EX operand selects; 00 regfile, 01 EX/MEM ALU result, 10 WB data.
- `stall_cnt` out CNT_W: count of cycles with a hazard stall.

## Operation
- Shadow scoreboard holds `{rd, wr, ld}` for EX, MEM and WB. `wr` is cleared when rd == 0.
- On `pipe_en`: WB←MEM, MEM←EX. EX←ID fields when `id_valid`, not bubble and not flush; otherwise EX←0.
- Match(stage, rsN) = `id_valid` & `id_use_rsN` & stage.wr & stage.rd == rsN & rsN != 0.
- **freeze** = `mem_req` & !`mem_ready`. Effects: `pc_en`=`ifid_en`=`pipe_en`=0, no flush, scoreboard and fwd regs hold, counter holds.
- **flush** (no freeze, `ex_branch_taken`): `pc_en`=1, `ifid_en`=1, `ifid_flush`=1, `pipe_en`=1, `idex_bubble`=1. Flush beats stall.
- **stall** (no freeze, no flush, hazard): `pc_en`=0, `ifid_en`=0, `pipe_en`=1, `idex_bubble`=1. Counter increments, saturating at all-ones.
- **normal**: all enables 1, flush and bubble 0.
- Hazard with FORWARD_EN:
  - EX match with `ld`: stall.
  - WB match not shadowed by an EX or MEM match: stall. The regfile writes on the edge and reads combinationally, so a same-cycle read is stale.
- Hazard without FORWARD_EN: any match in EX, MEM or WB stalls.
- Forward select, evaluated per operand when ID advances normally (priority EX > MEM):
  - EX non-load match → next fwd 01.
  - else MEM match → next fwd 10.
  - else → 00.
- On bubble or flush, next fwd = 00.

## Timing
- Controls are combinational from inputs and scoreboard; same-cycle.
- `fwd_a/b` are valid in the cycle the instruction occupies EX (one-cycle latency from ID).
- Load-use stall (with FORWARD_EN): one cycle, then fwd 10.
- Without FORWARD_EN: dependent instruction stalls 3 cycles after an adjacent producer.
- Freeze may last any number of cycles. State is unchanged across it; a branch asserted during freeze flushes on the first non-freeze cycle.
- Reset values:
  - Scoreboard all zero; `fwd_a`=`fwd_b`=00; `stall_cnt`=0.
  - While `rst` is high: `pc_en`=`ifid_en`=`pipe_en`=0, `ifid_flush`=`idex_bubble`=1.
- Reset mid-stall or mid-freeze clears everything on the next edge; no stale stall after release.

## Configuration
- `HAZARD_FORWARD_EN` defined: forwarding path active; stalls only for load-use and WB-read cases.
- Undefined: `fwd_a`/`fwd_b` tied to 00, no forwarding state, full interlock on any in-flight match.

## Structure
- `cpu_pkg`: FWD_REG/FWD_EXMEM/FWD_WB encodings, RV32I opcode constants, scoreboard entry struct `{rd, wr, ld}`.
- Sub-module `hazard_scoreboard`: 3-entry shadow shift with advance/insert/clear and match outputs. `hazard_ctrl` holds priority logic, fwd regs and counter.

## Test plan
- With FORWARD_EN: `add x5,x1,x2` then `add x6,x5,x3` → no stall; second instruction sees `fwd_a`=01 in EX.
- `lw x5,0(x1)` then `add x6,x5,x5` → one stall cycle (`pc_en`=0, bubble), then `fwd_a`=`fwd_b`=10; `stall_cnt`=1.
- FORWARD_EN undefined: same add pair → 3 stall cycles; `fwd_a` stays 00; `stall_cnt`=3.
- `ex_branch_taken`=1 while ID has hazard on x5 → `ifid_flush`=1, `idex_bubble`=1, `pc_en`=1; no stall counted.
- `mem_req`=1, `mem_ready`=0 for 4 cycles with branch taken → all enables 0 for 4 cycles, flush on cycle 5.
- Dependency on x0 (`addi x0,...` then `add x6,x0,x0`) → no stall, fwd 00. Assert `rst` mid-stall → scoreboard zero, `stall_cnt`=0 next cycle.
